// File: rtl/rr_req_sched_16.sv
// Request collector and grant issuer for 16 sources: per-source pending counters feed an
// internal round-robin search, and the registered winner is offered on a valid/ready interface.
module rr_req_sched_16 #(
   parameter int unsigned CNT_W = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req_pulse,
   input  logic [15:0] req_mask,
   output logic        gnt_valid,
   output logic [3:0]  gnt_idx,
   input  logic        gnt_ready,
   output logic [15:0] pend_nz,
   output logic [15:0] ovf_err,
   input  logic        ovf_clr
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                  state_q, state_d;
   logic [15:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]             ovf_q, ovf_d, ovf_new;
   logic [15:0]             pend_q, pend_d;
   logic [3:0]              rr_cnt_q, rr_cnt_d;
   logic [3:0]              gnt_idx_q, gnt_idx_d;
   logic [3:0]              rr_eff;
   logic [15:0]             dec;
   logic [15:0]             req_list;
   logic                    accept;
   logic                    req_prsnt;
   logic [3:0]              req_idx;
   logic [3:0]              cand;
   logic                    load_gnt;

   assign accept = gnt_valid & gnt_ready;

   // Counter update, overflow detection and arbiter request vector
   always_comb begin
      cnt_d   = cnt_q;
      ovf_new = '0;
      dec     = '0;
      req_list = '0;
      for (int i = 0; i < 16; i++) begin
         dec[i] = accept & (gnt_idx_q == 4'(i));
         if (req_pulse[i] && !dec[i]) begin
            if (cnt_q[i] == CntMax) ovf_new[i] = 1'b1;
            else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (!req_pulse[i] && dec[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         // This cycle's pulses are deliberately left out of arbitration.
         req_list[i] = ((cnt_q[i] - CNT_W'(dec[i])) != '0) & ~req_mask[i];
      end
      ovf_d = (ovf_clr ? 16'h0000 : ovf_q) | ovf_new;
      for (int i = 0; i < 16; i++) pend_d[i] = (cnt_d[i] != '0);
   end

   // Round-robin search upward from rr_eff; scanning down lets the nearest candidate win.
   always_comb begin
      rr_eff    = accept ? gnt_idx_q + 4'd1 : rr_cnt_q;
      req_prsnt = 1'b0;
      req_idx   = '0;
      cand      = '0;
      for (int j = 15; j >= 0; j--) begin
         cand = rr_eff + 4'(j);
         if (req_list[cand]) begin
            req_prsnt = 1'b1;
            req_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         ovf_q     <= '0;
         pend_q    <= '0;
         rr_cnt_q  <= '0;
         gnt_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         pend_q    <= pend_d;
         rr_cnt_q  <= rr_cnt_d;
         gnt_idx_q <= gnt_idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_prsnt) state_d = StGrant;
         StGrant: if (gnt_ready && !req_prsnt) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A held grant (valid without ready) is never re-arbitrated.
   always_comb begin
      gnt_valid = (state_q == StGrant);
      load_gnt  = req_prsnt & (!gnt_valid | gnt_ready);
      gnt_idx_d = load_gnt ? req_idx : gnt_idx_q;
      rr_cnt_d  = accept ? gnt_idx_q + 4'd1 : rr_cnt_q;
   end

   assign gnt_idx = gnt_idx_q;
   assign pend_nz = pend_q;
   assign ovf_err = ovf_q;

endmodule
